// File: rtl/rot_pkg.sv
// Shared types and mode encodings for the sequential left rotator.
// Imported by the rotator top and its single-stage helper.
package rot_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } rot_state_t;

   localparam logic ROT_MODE_ROTATE = 1'b0;
   localparam logic ROT_MODE_SHIFT  = 1'b1;

endpackage

// File: rtl/rotl_stage.sv
// One log-shifter stage: conditionally moves d left by 2**k_pow bits,
// either wrapping the MSBs around (rotate) or zero-filling (shift).
module rotl_stage
   import rot_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] d,
   input  logic [AMT_W-1:0] k_pow,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] q
);

   logic [2*WIDTH-1:0] w_dbl;
   logic [WIDTH-1:0]   w_rot;
   logic [WIDTH-1:0]   w_shl;
   logic [31:0]        w_dist;

   always_comb begin
      w_dist = 32'd1 << k_pow;
      // Rotating the doubled word leaves the wrapped bits in the upper half.
      w_dbl  = {d, d} << w_dist;
      w_rot  = w_dbl[2*WIDTH-1:WIDTH];
      w_shl  = d << w_dist;
      q      = d;
      if (en) begin
         q = (mode == ROT_MODE_SHIFT) ? w_shl : w_rot;
      end
   end

endmodule

// File: rtl/rotl16_seq.sv
// Multi-cycle left rotator / logical left shifter: one power-of-two
// stage per clock, with a start/busy/done handshake and a held result.
module rotl16_seq
   import rot_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y
);

   rot_state_t       r_state;
   rot_state_t       w_next_state;
   logic [WIDTH-1:0] r_work;
   logic [AMT_W-1:0] r_amt;
   logic             r_mode;
   logic [AMT_W-1:0] r_stg;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_stage_q;
   logic             w_last;

   assign w_last = (r_stg == AMT_W'(AMT_W-1));
   assign y      = r_y;

   rotl_stage #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_stage (
      .d     (r_work),
      .k_pow (r_stg),
      .en    (r_amt[r_stg]),
      .mode  (r_mode),
      .q     (w_stage_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next_state = SHIFT;
         SHIFT:   if (w_last) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (r_state)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_work <= '0;
         r_amt  <= '0;
         r_mode <= ROT_MODE_ROTATE;
         r_stg  <= '0;
         r_y    <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_work <= a;
                  r_amt  <= amt;
                  r_mode <= mode;
                  r_stg  <= '0;
               end
            end
            SHIFT: begin
               r_work <= w_stage_q;
               r_stg  <= r_stg + 1'b1;
               if (w_last) begin
                  r_y <= w_stage_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rotl16_seq.sv
// Self-checking bench for rotl16_seq: bit-level reference model,
// per-cycle output compare, directed cases and random operations.
module tb_rotl16_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] a;
   logic [3:0]  amt;
   logic        mode;
   logic        busy;
   logic        done;
   logic [15:0] y;

   int n_err;
   int n_chk;

   rotl16_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .amt   (amt),
      .mode  (mode),
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: place each source bit at its destination position.
   function automatic logic [15:0] golden(input logic [15:0] v,
                                          input int k,
                                          input logic m);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (m == 1'b0) r[(i + k) % 16] = v[i];
         else if (i + k < 16) r[i + k] = v[i];
      end
      return r;
   endfunction

   task automatic check(input logic ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Operation timeline model: ph counts cycles since accept (0 = idle).
   int          ph;
   logic [15:0] m_a;
   int          m_k;
   logic        m_m;
   logic [15:0] m_y;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph  <= 0;
         m_y <= '0;
      end else if (ph == 0) begin
         if (start) begin
            ph  <= 1;
            m_a <= a;
            m_k <= int'(amt);
            m_m <= mode;
         end
      end else if (ph == 4) begin
         m_y <= golden(m_a, m_k, m_m);
         ph  <= 5;
      end else if (ph == 5) begin
         ph <= 0;
      end else begin
         ph <= ph + 1;
      end
   end

   always @(negedge clk) begin
      check(busy == (ph >= 1 && ph <= 4), "busy", 32'(busy),
            32'(ph >= 1 && ph <= 4));
      check(done == (ph == 5), "done", 32'(done), 32'(ph == 5));
      check(y == m_y, "y_model", 32'(y), 32'(m_y));
      check(!(busy && done), "busy_done_excl", 32'({busy, done}), 32'd0);
   end

   // Launch one op, wait for done (bounded), check latency and y.
   task automatic do_op(input logic [15:0] av, input logic [3:0] kv,
                        input logic mv, input logic [15:0] exp_y,
                        input string name);
      int lat;
      @(posedge clk);
      #2;
      a = av; amt = kv; mode = mv; start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      a = 16'($urandom);
      amt = 4'($urandom);
      mode = 1'($urandom);
      lat = 0;
      while (lat < 12) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      check(done == 1'b1, {name, "_timeout"}, 32'(done), 32'd1);
      check(lat == 5, {name, "_latency"}, 32'(lat), 32'd5);
      check(y == exp_y, name, 32'(y), 32'(exp_y));
   endtask

   int npulse;

   initial begin
      n_err = 0;
      n_chk = 0;
      reset = 1'b1;
      start = 1'b0;
      a = '0;
      amt = '0;
      mode = 1'b0;
      #1;
      check(busy == 1'b0 && done == 1'b0, "reset_flags",
            32'({busy, done}), 32'd0);
      check(y == 16'h0000, "reset_y", 32'(y), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;

      do_op(16'h8001, 4'd1, 1'b0, 16'h0003, "rot_8001_1");
      do_op(16'h1234, 4'd4, 1'b0, 16'h2341, "rot_1234_4");
      do_op(16'hF00F, 4'd15, 1'b0, 16'hF807, "rot_F00F_15");
      do_op(16'hFFFF, 4'd8, 1'b1, 16'hFF00, "shl_FFFF_8");
      do_op(16'hA5A5, 4'd0, 1'b1, 16'hA5A5, "shl_A5A5_0");

      // Start during busy must be ignored.
      @(posedge clk);
      #2;
      a = 16'h0001; amt = 4'd3; mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #2;
      a = 16'hFFFF; amt = 4'd7; mode = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      start = 1'b0;
      npulse = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check(npulse == 1, "busy_start_pulses", 32'(npulse), 32'd1);
      check(y == 16'h0008, "busy_start_y", 32'(y), 32'h0008);

      // Asynchronous reset in the second shift cycle.
      @(posedge clk);
      #2;
      a = 16'h00FF; amt = 4'd5; mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check(busy == 1'b0 && done == 1'b0, "async_rst_flags",
            32'({busy, done}), 32'd0);
      check(y == 16'h0000, "async_rst_y", 32'(y), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check(npulse == 0, "no_done_after_rst", 32'(npulse), 32'd0);
      do_op(16'h0F00, 4'd6, 1'b0, 16'hC003, "post_rst_rot");

      // Sweep all amounts for a single set bit, both modes.
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 16; k++) begin
            do_op(16'h0001, 4'(k), 1'(m), golden(16'h0001, k, 1'(m)),
                  "sweep");
         end
      end

      // Random operations with idle gaps; y must hold across gaps.
      for (int i = 0; i < 40; i++) begin
         logic [15:0] rv;
         logic [3:0]  rk;
         logic        rm;
         rv = 16'($urandom);
         rk = 4'($urandom_range(15, 0));
         rm = 1'($urandom);
         do_op(rv, rk, rm, golden(rv, int'(rk), rm), "random");
         repeat ($urandom_range(3, 0)) @(negedge clk);
         check(y == golden(rv, int'(rk), rm), "hold_y", 32'(y),
               32'(golden(rv, int'(rk), rm)));
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
